div_issue_ctrl: RTL and testbench

Request front-end for the 8-bit radix-2 serial divider. Accepts tagged divide requests on a valid/ready interface and buffers them in a small FIFO. Issues them one at a time to the divider's one-shot `opn_valid` interface, waits for completion, then returns quotient, remainder, tag and error status on a valid/ready response interface. Divide-by-zero is short-circuited, and a watchdog protects against a divider that never answers.

---
 rtl/div_pkg.sv | 34 +++
 rtl/div_req_fifo.sv | 73 +++++++
 rtl/div_issue_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the serial-divider request front-end.
package div_pkg;

    // Operand width of the radix-2 serial divider
    localparam int DATA_W = 8;
    localparam int RES_W  = 2 * DATA_W;

    // Field positions inside the divider result word
    localparam int Q_LSB = 0;
    localparam int R_LSB = 8;

    // Response error codes
    localparam int ERR_W = 2;
    localparam logic [ERR_W-1:0] ERR_OK      = 2'b00;
    localparam logic [ERR_W-1:0] ERR_DIV0    = 2'b01;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'b10;

    // Quotient reported for a short-circuited divide-by-zero
    localparam logic [DATA_W-1:0] DIV0_QUOTIENT = 8'hFF;

    // Issue FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Extract one byte field (quotient or remainder) from a divider result
    function automatic logic [DATA_W-1:0] res_field(input logic [RES_W-1:0] res, input int lsb);
        return res[lsb +: DATA_W];
    endfunction

endpackage

// File: rtl/div_req_fifo.sv
// First-word-fall-through request FIFO; head entry is always visible on rdata.
module div_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 21
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pushes into a full FIFO and pops from an empty one are dropped
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers, cleared by reset so all contents are discarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful below count, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/div_issue_ctrl.sv
// Request front-end for the 8-bit serial divider: buffers tagged requests,
// issues one op at a time, short-circuits divide-by-zero and guards the
// divider with a watchdog.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready;
// req_valid/rsp_valid must hold their payload stable until that edge.
// div_opn_valid is a one-cycle start pulse with no back-pressure.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 31
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_sign,
    input  logic [DATA_W-1:0]  req_dividend,
    input  logic [DATA_W-1:0]  req_divisor,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               div_opn_valid,
    output logic               div_sign,
    output logic [DATA_W-1:0]  div_dividend,
    output logic [DATA_W-1:0]  div_divisor,
    input  logic               div_res_valid,
    input  logic [RES_W-1:0]   div_result,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_quotient,
    output logic [DATA_W-1:0]  rsp_remainder,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic [ERR_W-1:0]   rsp_err,
    output logic               busy
);

    localparam int FIFO_W = 1 + 2 * DATA_W + TAG_W;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WDOG_W = $clog2(TIMEOUT + 1);
    // Last watchdog value still spent in WAIT; the next WAIT cycle would exceed TIMEOUT
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    // FIFO interface
    logic              fifo_push;
    logic              fifo_pop;
    logic [FIFO_W-1:0] fifo_wdata;
    logic [FIFO_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    // Head-of-queue fields
    logic              head_sign;
    logic [DATA_W-1:0] head_dividend;
    logic [DATA_W-1:0] head_divisor;
    logic [TAG_W-1:0]  head_tag;
    logic              head_div0;

    // FSM and datapath registers
    state_e            state_q, state_d;
    logic              res_valid_q;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              op_sign_q, op_sign_d;
    logic [DATA_W-1:0] op_dividend_q, op_dividend_d;
    logic [DATA_W-1:0] op_divisor_q, op_divisor_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] rsp_quotient_q, rsp_quotient_d;
    logic [DATA_W-1:0] rsp_remainder_q, rsp_remainder_d;
    logic [ERR_W-1:0]  rsp_err_q, rsp_err_d;

    logic              res_edge;
    logic              wdog_expired;

    assign fifo_wdata = {req_sign, req_dividend, req_divisor, req_tag};
    assign fifo_push  = req_valid & req_ready;

    div_req_fifo #(
        .DEPTH (DEPTH),
        .W     (FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_sign     = fifo_rdata[FIFO_W-1];
    assign head_dividend = fifo_rdata[TAG_W+DATA_W +: DATA_W];
    assign head_divisor  = fifo_rdata[TAG_W +: DATA_W];
    assign head_tag      = fifo_rdata[TAG_W-1:0];
    assign head_div0     = (head_divisor == '0);

    // Only a fresh rising edge counts, so a result left high from a timed-out op is ignored
    assign res_edge     = div_res_valid & ~res_valid_q;
    assign wdog_expired = (wdog_q == WDOG_LAST);

    // State register plus all datapath flops; async reset drops any in-flight op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            res_valid_q     <= 1'b0;
            wdog_q          <= '0;
            op_sign_q       <= 1'b0;
            op_dividend_q   <= '0;
            op_divisor_q    <= '0;
            tag_q           <= '0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_err_q       <= ERR_OK;
        end else begin
            state_q         <= state_d;
            res_valid_q     <= div_res_valid;
            wdog_q          <= wdog_d;
            op_sign_q       <= op_sign_d;
            op_dividend_q   <= op_dividend_d;
            op_divisor_q    <= op_divisor_d;
            tag_q           <= tag_d;
            rsp_quotient_q  <= rsp_quotient_d;
            rsp_remainder_q <= rsp_remainder_d;
            rsp_err_q       <= rsp_err_d;
        end
    end

    // Next-state logic; IDLE waits for the previous result strobe to drop before popping
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !res_valid_q) begin
                    fifo_pop = 1'b1;
                    state_d  = head_div0 ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (res_edge || wdog_expired) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: op capture on pop, watchdog, and response capture
    always_comb begin
        wdog_d          = wdog_q;
        op_sign_d       = op_sign_q;
        op_dividend_d   = op_dividend_q;
        op_divisor_d    = op_divisor_q;
        tag_d           = tag_q;
        rsp_quotient_d  = rsp_quotient_q;
        rsp_remainder_d = rsp_remainder_q;
        rsp_err_d       = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_pop) begin
                    tag_d = head_tag;
                    if (head_div0) begin
                        // Divider operands stay untouched for a divide-by-zero
                        rsp_quotient_d  = DIV0_QUOTIENT;
                        rsp_remainder_d = head_dividend;
                        rsp_err_d       = ERR_DIV0;
                    end else begin
                        op_sign_d     = head_sign;
                        op_dividend_d = head_dividend;
                        op_divisor_d  = head_divisor;
                    end
                end
            end
            ST_ISSUE: wdog_d = '0;
            ST_WAIT: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (res_edge) begin
                    rsp_quotient_d  = res_field(div_result, Q_LSB);
                    rsp_remainder_d = res_field(div_result, R_LSB);
                    rsp_err_d       = ERR_OK;
                end else if (wdog_expired) begin
                    rsp_quotient_d  = '0;
                    rsp_remainder_d = '0;
                    rsp_err_d       = ERR_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from registered state; req_ready is forced low while in reset
    always_comb begin
        req_ready     = ~fifo_full & ~rst;
        div_opn_valid = (state_q == ST_ISSUE);
        div_sign      = op_sign_q;
        div_dividend  = op_dividend_q;
        div_divisor   = op_divisor_q;
        rsp_valid     = (state_q == ST_RESP);
        rsp_quotient  = rsp_quotient_q;
        rsp_remainder = rsp_remainder_q;
        rsp_tag       = tag_q;
        rsp_err       = rsp_err_q;
        busy          = (state_q != ST_IDLE) || (fifo_count != '0);
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: single linear stimulus sequence with
// hand-computed expectations checked by immediate assertions.
module tb_div_issue_ctrl;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 31;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_sign;
    logic [7:0]       req_dividend;
    logic [7:0]       req_divisor;
    logic [TAG_W-1:0] req_tag;
    logic             div_opn_valid;
    logic             div_sign;
    logic [7:0]       div_dividend;
    logic [7:0]       div_divisor;
    logic             div_res_valid;
    logic [15:0]      div_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_quotient;
    logic [7:0]       rsp_remainder;
    logic [TAG_W-1:0] rsp_tag;
    logic [1:0]       rsp_err;
    logic             busy;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int opn_cnt   = 0;

    div_issue_ctrl #(
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_sign      (req_sign),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .req_tag       (req_tag),
        .div_opn_valid (div_opn_valid),
        .div_sign      (div_sign),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_res_valid (div_res_valid),
        .div_result    (div_result),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_tag       (rsp_tag),
        .rsp_err       (rsp_err),
        .busy          (busy)
    );

    // Clock and cycle/issue-pulse counters
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (div_opn_valid) begin
            opn_cnt <= opn_cnt + 1;
        end
    end

    // All driving and sampling happens on the falling edge
    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input logic [7:0] q, input logic [7:0] r,
                             input logic [TAG_W-1:0] t, input logic [1:0] e);
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_quot"}, rsp_quotient, q);
        check({tag, "_rem"}, rsp_remainder, r);
        check({tag, "_tag"}, rsp_tag, t);
        check({tag, "_err"}, rsp_err, e);
    endtask

    // Offer one request for a single cycle
    task automatic push_req(input string tag, input logic s, input logic [7:0] dvd,
                            input logic [7:0] dvs, input logic [TAG_W-1:0] t);
        req_valid    = 1'b1;
        req_sign     = s;
        req_dividend = dvd;
        req_divisor  = dvs;
        req_tag      = t;
        check({tag, "_push_ready"}, req_ready, 1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic wait_opn(input string tag);
        for (int k = 0; k < 100 && !div_opn_valid; k++) step();
        check({tag, "_opn_seen"}, div_opn_valid, 1);
    endtask

    task automatic wait_opn_cnt(input string tag, input int target);
        for (int k = 0; k < 100 && opn_cnt < target; k++) step();
        check({tag, "_opn_cnt"}, opn_cnt, target);
    endtask

    task automatic wait_rsp(input string tag);
        for (int k = 0; k < 100 && !rsp_valid; k++) step();
        check({tag, "_rsp_seen"}, rsp_valid, 1);
    endtask

    // Vectors for the FIFO-fill test: tags 1 and 3 are divide-by-zero
    logic [7:0] v_sgn [5] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd0};
    logic [7:0] v_dvd [5] = '{8'd200, 8'h11, 8'hEC, 8'h80, 8'd255};
    logic [7:0] v_dvs [5] = '{8'd9, 8'd0, 8'd3, 8'd0, 8'd16};
    logic [7:0] v_q   [5] = '{8'd22, 8'hFF, 8'hFA, 8'hFF, 8'd15};
    logic [7:0] v_r   [5] = '{8'd2, 8'h11, 8'hFE, 8'h80, 8'd15};

    initial begin
        int base;
        int nissue;
        int c0;
        int seen;

        rst           = 1'b1;
        req_valid     = 1'b0;
        req_sign      = 1'b0;
        req_dividend  = '0;
        req_divisor   = '0;
        req_tag       = '0;
        div_res_valid = 1'b0;
        div_result    = '0;
        rsp_ready     = 1'b0;
        repeat (2) step();

        // Reset values
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_opn", div_opn_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", rsp_err, 0);
        rst = 1'b0;
        step();
        check("rel_req_ready", req_ready, 1);

        // Unsigned 100/7, result returned 20 cycles after the start pulse
        base = opn_cnt;
        push_req("t1", 1'b0, 8'd100, 8'd7, 4'd5);
        check("t1_busy", busy, 1);
        check("t1_opn_early", div_opn_valid, 0);
        step();
        check("t1_opn", div_opn_valid, 1);
        check("t1_dvd", div_dividend, 100);
        check("t1_dvs", div_divisor, 7);
        check("t1_sign", div_sign, 0);
        repeat (20) step();
        check("t1_no_early_rsp", rsp_valid, 0);
        div_res_valid = 1'b1;
        div_result    = {8'd2, 8'd14};
        step();
        div_res_valid = 1'b0;
        check_rsp("t1", 8'd14, 8'd2, 4'd5, 2'b00);
        check("t1_one_pulse", opn_cnt - base, 1);
        ack();
        check("t1_rsp_drop", rsp_valid, 0);
        check("t1_idle", busy, 0);

        // Divide-by-zero, then response held 10 cycles with rsp_ready low
        base = opn_cnt;
        push_req("t2", 1'b0, 8'h5A, 8'h00, 4'd3);
        check("t2_not_yet", rsp_valid, 0);
        step();
        check_rsp("t2", 8'hFF, 8'h5A, 4'd3, 2'b01);
        for (int i = 0; i < 10; i++) begin
            step();
            check_rsp("t2_hold", 8'hFF, 8'h5A, 4'd3, 2'b01);
        end
        check("t2_no_opn", opn_cnt - base, 0);
        ack();
        check("t2_rsp_drop", rsp_valid, 0);

        // Stall FSM in RESP, then fill the FIFO with tags 0..4
        push_req("t3_stall", 1'b0, 8'h33, 8'h00, 4'd9);
        step();
        check("t3_stall_tag", rsp_tag, 9);
        for (int i = 0; i < 4; i++) begin
            push_req("t3_fill", v_sgn[i][0], v_dvd[i], v_dvs[i], TAG_W'(i));
        end
        req_valid    = 1'b1;
        req_sign     = v_sgn[4][0];
        req_dividend = v_dvd[4];
        req_divisor  = v_dvs[4];
        req_tag      = 4'd4;
        check("t3_full", req_ready, 0);
        repeat (3) begin
            step();
            check("t3_full_hold", req_ready, 0);
        end
        check("t3_busy", busy, 1);
        base = opn_cnt;
        ack();
        check("t3_full_at_pop", req_ready, 0);
        step();
        check("t3_ready_reopen", req_ready, 1);
        step();
        req_valid = 1'b0;
        nissue = base;
        for (int i = 0; i < 5; i++) begin
            if (v_dvs[i] != 8'd0) begin
                nissue++;
                wait_opn_cnt("t3", nissue);
                check("t3_op_dvd", div_dividend, v_dvd[i]);
                check("t3_op_dvs", div_divisor, v_dvs[i]);
                check("t3_op_sign", div_sign, v_sgn[i][0]);
                div_res_valid = 1'b1;
                div_result    = {v_r[i], v_q[i]};
                step();
                div_res_valid = 1'b0;
            end
            wait_rsp("t3");
            check_rsp("t3_order", v_q[i], v_r[i], TAG_W'(i), (v_dvs[i] == 8'd0) ? 2'b01 : 2'b00);
            ack();
        end
        check("t3_issue_count", opn_cnt - base, 3);
        check("t3_drained", busy, 0);

        // Divider never answers: watchdog timeout, then late result ignored
        push_req("t4", 1'b0, 8'd50, 8'd5, 4'd7);
        wait_opn("t4");
        c0 = cyc;
        for (int k = 0; k < 100 && !rsp_valid; k++) step();
        check("t4_rsp_seen", rsp_valid, 1);
        check("t4_latency", cyc - c0, TIMEOUT + 1);
        check_rsp("t4", 8'd0, 8'd0, 4'd7, 2'b10);
        div_res_valid = 1'b1;
        div_result    = 16'hABCD;
        step();
        check_rsp("t4_late", 8'd0, 8'd0, 4'd7, 2'b10);
        base = opn_cnt;
        rsp_ready = 1'b1;
        push_req("t4b", 1'b0, 8'd50, 8'd5, 4'd8);
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_blocked_rsp", rsp_valid, 0);
            check("t4_blocked_opn", div_opn_valid, 0);
        end
        check("t4_blocked_busy", busy, 1);
        check("t4_blocked_cnt", opn_cnt - base, 0);
        div_res_valid = 1'b0;
        step();
        check("t4_reissue_early", div_opn_valid, 0);
        step();
        check("t4_reissue", div_opn_valid, 1);
        check("t4_reissue_dvd", div_dividend, 50);
        step();
        div_res_valid = 1'b1;
        div_result    = {8'd0, 8'd10};
        step();
        div_res_valid = 1'b0;
        check_rsp("t4b", 8'd10, 8'd0, 4'd8, 2'b00);
        ack();

        // Reset while waiting on the divider with two ops queued
        push_req("t6", 1'b0, 8'd90, 8'd9, 4'd1);
        wait_opn("t6");
        push_req("t6_q1", 1'b0, 8'd1, 8'd1, 4'd2);
        push_req("t6_q2", 1'b0, 8'd2, 8'd1, 4'd3);
        check("t6_inflight", busy, 1);
        check("t6_dvd_before", div_dividend, 90);
        rst = 1'b1;
        #1;
        check("t6_rst_ready", req_ready, 0);
        check("t6_rst_opn", div_opn_valid, 0);
        check("t6_rst_sign", div_sign, 0);
        check("t6_rst_dvd", div_dividend, 0);
        check("t6_rst_dvs", div_divisor, 0);
        check("t6_rst_rsp_valid", rsp_valid, 0);
        check("t6_rst_quot", rsp_quotient, 0);
        check("t6_rst_rem", rsp_remainder, 0);
        check("t6_rst_tag", rsp_tag, 0);
        check("t6_rst_err", rsp_err, 0);
        check("t6_rst_busy", busy, 0);
        step();
        step();
        rst  = 1'b0;
        base = opn_cnt;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rsp_valid) seen++;
        end
        check("t6_no_rsp", seen, 0);
        check("t6_no_opn", opn_cnt - base, 0);
        check("t6_empty", busy, 0);
        push_req("t6_fresh", 1'b1, 8'hF0, 8'h00, 4'hC);
        step();
        check_rsp("t6_fresh", 8'hFF, 8'hF0, 4'hC, 2'b01);
        ack();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
